// File: rtl/dem_pkg.sv
// Shared constants, FSM state type and code clamp for the 6-element DEM selector.
package dem_pkg;

  localparam int N_ELEM        = 6;
  localparam int CODE_W        = 3;
  localparam int ACC_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    UPD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Codes above the element count enable every element.
  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
    return (code > 3'd6) ? 3'd6 : code;
  endfunction

endpackage

// File: rtl/dem_vq_select_min6_idx.sv
// Masked argmin over six usage counters with a rotating tie-break start.
// Ties go to the first unmasked element met when walking from start upward mod 6.
module min6_idx
  import dem_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [N_ELEM-1:0][ACC_W-1:0] vals,
  input  logic [N_ELEM-1:0]            mask,
  input  logic [2:0]                   start,
  output logic [N_ELEM-1:0]            win,
  output logic                         valid
);

  int               idx_s;
  int               st_s;
  logic [ACC_W-1:0] best_s;

  // Walk elements in priority order; strict less-than keeps the earliest on ties.
  always_comb begin
    win    = '0;
    valid  = 1'b0;
    best_s = '0;
    idx_s  = 0;
    if (start > 3'd5) begin
      st_s = 0;
    end else begin
      st_s = int'(start);
    end
    for (int j = 0; j < N_ELEM; j++) begin
      idx_s = st_s + j;
      if (idx_s >= N_ELEM) begin
        idx_s = idx_s - N_ELEM;
      end else begin
        idx_s = idx_s;
      end
      if (!mask[idx_s] && (!valid || (vals[idx_s] < best_s))) begin
        win        = '0;
        win[idx_s] = 1'b1;
        best_s     = vals[idx_s];
        valid      = 1'b1;
      end else begin
        win = win;
      end
    end
  end

endmodule

// File: rtl/dem_vq_select.sv
// Minimum-usage element selector for the 6-element unit DAC.
// Optional feature: define DEM_VQ_DITHER_EN for a rotating tie-break pointer.
module dem_vq_select #(
  parameter int ACC_W = dem_pkg::ACC_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_sel,
  output logic       busy
);
  import dem_pkg::*;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t                       state_r, state_nxt;
  logic [N_ELEM-1:0][ACC_W-1:0] acc_r, acc_nxt, acc_p_s;
  logic [ACC_W-1:0]             min_s;
  logic [N_ELEM-1:0]            sel_r, sel_nxt, win_s, out_sel_r, out_sel_nxt;
  logic                         win_valid_s;
  logic [CODE_W-1:0]            cnt_r, cnt_nxt, k_s;
  logic [2:0]                   start_s;
  logic                         in_ready_r, out_valid_r, busy_r;

  assign k_s = clamp_code(in_code);

`ifdef DEM_VQ_DITHER_EN
  logic [2:0] ptr_r;

  // Tie-break pointer advances once per conversion, wrapping 5 to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 3'd0;
    end else if (state_r == UPD) begin
      ptr_r <= (ptr_r >= 3'd5) ? 3'd0 : ptr_r + 3'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign start_s = ptr_r;
`else
  assign start_s = 3'd0;
`endif

  min6_idx #(.ACC_W(ACC_W)) u_min (
    .vals  (acc_r),
    .mask  (sel_r),
    .start (start_s),
    .win   (win_s),
    .valid (win_valid_s)
  );

  // Saturating usage add followed by the minimum used for re-normalisation.
  always_comb begin
    acc_p_s = acc_r;
    min_s   = ACC_MAX;
    for (int i = 0; i < N_ELEM; i++) begin
      if (acc_r[i] == ACC_MAX) begin
        acc_p_s[i] = acc_r[i];
      end else begin
        acc_p_s[i] = acc_r[i] + {{(ACC_W-1){1'b0}}, sel_r[i]};
      end
    end
    for (int i = 0; i < N_ELEM; i++) begin
      if (acc_p_s[i] < min_s) begin
        min_s = acc_p_s[i];
      end else begin
        min_s = min_s;
      end
    end
  end

  // Next-state and datapath decode for the accept/pick/update/present sequence.
  always_comb begin
    state_nxt   = state_r;
    sel_nxt     = sel_r;
    cnt_nxt     = cnt_r;
    acc_nxt     = acc_r;
    out_sel_nxt = out_sel_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          cnt_nxt   = k_s;
          sel_nxt   = '0;
          state_nxt = (k_s != 3'd0) ? SEL : UPD;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEL: begin
        if (win_valid_s && (cnt_r != 3'd0)) begin
          sel_nxt   = sel_r | win_s;
          cnt_nxt   = cnt_r - 3'd1;
          state_nxt = (cnt_r == 3'd1) ? UPD : SEL;
        end else begin
          state_nxt = UPD;
        end
      end
      UPD: begin
        for (int i = 0; i < N_ELEM; i++) begin
          acc_nxt[i] = acc_p_s[i] - min_s;
        end
        out_sel_nxt = sel_r;
        state_nxt   = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = OUT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered handshake flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      sel_r       <= '0;
      cnt_r       <= 3'd0;
      out_sel_r   <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      acc_r       <= acc_nxt;
      sel_r       <= sel_nxt;
      cnt_r       <= cnt_nxt;
      out_sel_r   <= out_sel_nxt;
      in_ready_r  <= (state_nxt == IDLE);
      out_valid_r <= (state_nxt == OUT);
      busy_r      <= (state_nxt != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_sel   = out_sel_r;

endmodule
